// File: rtl/fft_input_framer.sv
// fft_input_framer: serial-to-frame feeder for a radix-4 SDF FFT.
// Buffers whole frames of real samples in a 2-bank ping-pong store. It replays
// each frame as Num_of_samples/4 consecutive 4-lane beats. Lane k of beat t
// carries x[k*Q + t].
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         serial sample handshake
//   in_data, in_last          sample x[n] and end-of-frame marker
//   input_en                  beat valid towards the FFT
//   input_real_0..3           beat lanes (hold their value while input_en=0)
//   frame_err                 one-cycle pulse when a malformed frame is dropped
module fft_input_framer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned Num_of_samples = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             input_en,
  output logic [WIDTH-1:0] input_real_0,
  output logic [WIDTH-1:0] input_real_1,
  output logic [WIDTH-1:0] input_real_2,
  output logic [WIDTH-1:0] input_real_3,
  output logic             frame_err
);

  localparam int unsigned N     = Num_of_samples;
  localparam int unsigned Q     = N / 4;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned T_W   = $clog2(Q);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Ping-pong sample store, one bank per frame
  logic [WIDTH-1:0] mem_q [2][N];

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, rd_bank_q;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [T_W-1:0]   t_q;
  state_t           state_q;

  logic             input_en_q;
  logic [WIDTH-1:0] real0_q, real1_q, real2_q, real3_q;
  logic             frame_err_q;

  logic wr_fire, wr_at_end, wr_done, wr_err, rd_done, other_full;

  // Readiness comes from registered flags only, so a bank freed this cycle
  // is writable from the next cycle on
  assign in_ready = ~reset & ~full_q[wr_bank_q];

  // Write-side decode and next-state
  always_comb begin
    wr_fire   = in_valid & in_ready;
    wr_at_end = (wr_idx_q == IDX_W'(N - 1));
    wr_done   = wr_fire & wr_at_end & in_last;
    wr_err    = wr_fire & (wr_at_end ^ in_last);
    wr_idx_d  = wr_idx_q;
    if (wr_fire) begin
      if (wr_at_end || in_last) wr_idx_d = '0;
      else                      wr_idx_d = wr_idx_q + 1'b1;
    end

    rd_done = (state_q == STREAM) && (t_q == T_W'(Q - 1));
    // The reader never holds the bank being written, so a completing write
    // always lands in the other bank
    other_full = full_q[~rd_bank_q] | (wr_done & (wr_bank_q != rd_bank_q));

    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  // Sample store write port; contents need no reset since flags gate all reads
  always_ff @(posedge clock) begin
    if (wr_fire) mem_q[wr_bank_q][wr_idx_q] <= in_data;
  end

  // Bank bookkeeping, read FSM and registered beat outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      t_q         <= '0;
      state_q     <= IDLE;
      input_en_q  <= 1'b0;
      real0_q     <= '0;
      real1_q     <= '0;
      real2_q     <= '0;
      real3_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_idx_q    <= wr_idx_d;
      frame_err_q <= wr_err;
      if (wr_done) wr_bank_q <= ~wr_bank_q;

      case (state_q)
        IDLE: begin
          input_en_q <= 1'b0;
          if (full_q[rd_bank_q]) begin
            state_q <= STREAM;
            t_q     <= '0;
          end
        end
        STREAM: begin
          input_en_q <= 1'b1;
          real0_q    <= mem_q[rd_bank_q][{2'd0, t_q}];
          real1_q    <= mem_q[rd_bank_q][{2'd1, t_q}];
          real2_q    <= mem_q[rd_bank_q][{2'd2, t_q}];
          real3_q    <= mem_q[rd_bank_q][{2'd3, t_q}];
          if (rd_done) begin
            rd_bank_q <= ~rd_bank_q;
            t_q       <= '0;
            // Continue straight into the next frame when it is already there
            if (!other_full) state_q <= IDLE;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign input_en     = input_en_q;
  assign input_real_0 = real0_q;
  assign input_real_1 = real1_q;
  assign input_real_2 = real2_q;
  assign input_real_3 = real3_q;
  assign frame_err    = frame_err_q;

endmodule
